// File: rtl/signed_sat_accumulator.sv
// Streaming signed accumulator: saturating-adds COUNT samples per frame and
// emits the sum with a sticky saturation flag over a valid/ready handshake.
module signed_sat_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_sat
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_ACCUM = 1'b0, S_OUTPUT = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_acc, w_acc_nxt;
  logic                    r_sat, w_sat_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    w_beat;
  logic [WIDTH:0]          w_add;

  // Returns {overflow, clamped sum}; overflow shows as the top two bits of
  // the WIDTH+1-bit sum disagreeing.
  function automatic logic [WIDTH:0] sat_add(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      sat_add = {1'b1, (s[WIDTH] ? SMIN : SMAX)};
    else
      sat_add = {1'b0, s[WIDTH-1:0]};
  endfunction

  assign w_add = sat_add(r_acc, in_data);

  always_comb begin
    in_ready    = (r_state == S_ACCUM);
    out_valid   = (r_state == S_OUTPUT);
    out_data    = out_valid ? r_acc : '0;
    out_sat     = out_valid & r_sat;
    w_beat      = in_valid & in_ready;
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_sat_nxt   = r_sat;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_ACCUM: begin
        if (w_beat) begin
          w_acc_nxt = w_add[WIDTH-1:0];
          w_sat_nxt = r_sat | w_add[WIDTH];
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_OUTPUT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          w_acc_nxt   = '0;
          w_sat_nxt   = 1'b0;
          w_state_nxt = S_ACCUM;
        end
      end
      default: w_state_nxt = S_ACCUM;
    endcase
    // Abort wins over both handshakes, discarding any pending result.
    if (clear) begin
      w_acc_nxt   = '0;
      w_sat_nxt   = 1'b0;
      w_cnt_nxt   = '0;
      w_state_nxt = S_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_sat   <= w_sat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator: frame-level model plus directed vectors.
module tb_signed_sat_accumulator;
  localparam int W = 4;
  localparam int C = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] in_data = '0;
  logic                in_ready, out_valid, out_sat;
  logic signed [W-1:0] out_data;

  signed_sat_accumulator #(.WIDTH(W), .COUNT(C)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: collect accepted samples of a frame, then sum them with clamping.
  int m_q[$];
  bit m_pend = 1'b0;
  int m_data = 0;
  bit m_sat  = 1'b0;

  function automatic void frame_result();
    int a = 0;
    bit s = 1'b0;
    foreach (m_q[i]) begin
      a += m_q[i];
      if (a > 7)  begin a = 7;  s = 1'b1; end
      if (a < -8) begin a = -8; s = 1'b1; end
    end
    m_data = a;
    m_sat  = s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend = 1'b0;
    end else if (clear) begin
      m_q.delete();
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (out_ready) m_pend = 1'b0;
    end else if (in_valid) begin
      m_q.push_back(int'(in_data));
      if (m_q.size() == C) begin
        frame_result();
        m_q.delete();
        m_pend = 1'b1;
      end
    end
  end

  int got_d[$];
  int got_s[$];
  int gi = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(!m_pend));
      chk("out_valid", int'(out_valid), int'(m_pend));
      if (m_pend) begin
        chk("out_data", int'(out_data), m_data);
        chk("out_sat", int'(out_sat), int'(m_sat));
      end
      if (out_valid && out_ready && !clear) begin
        got_d.push_back(int'(out_data));
        got_s.push_back(int'(out_sat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = W'(d);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic expect_res(input string name, input int d, input int s);
    if (gi < got_d.size()) begin
      chk({name, "_data"}, got_d[gi], d);
      chk({name, "_sat"}, got_s[gi], s);
      gi++;
    end else begin
      chk({name, "_count"}, got_d.size(), gi + 1);
    end
  endtask

  initial begin
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);

    send(1); send(2); send(-1); send(3);
    chk("t1_valid_rise", int'(out_valid), 1);
    tick(1);
    chk("t1_valid_fall", int'(out_valid), 0);
    tick(1);
    expect_res("t1", 5, 0);

    send(7); send(7); send(-1); send(-1);
    tick(2);
    expect_res("t2", 5, 1);

    send(-8); send(-8); send(-8); send(3);
    tick(2);
    expect_res("t3a", -5, 1);
    send(0); send(0); send(0); send(0);
    tick(2);
    expect_res("t3b", 0, 0);

    out_ready = 1'b0;
    send(1); send(1); send(1); send(1);
    in_valid = 1'b1;
    in_data  = 4'sd1;
    repeat (5) begin
      tick(1);
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_data", int'(out_data), 4);
      chk("t4_hold_sat", int'(out_sat), 0);
      chk("t4_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick(2);
    in_valid = 1'b0;
    send(1); send(1); send(1);
    tick(2);
    expect_res("t4a", 4, 0);
    expect_res("t4b", 4, 0);

    send(3); send(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    send(1); send(1); send(1); send(1);
    tick(2);
    expect_res("t5a", 4, 0);
    out_ready = 1'b0;
    send(2); send(2); send(2); send(2);
    chk("t5_pending", int'(out_valid), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t5_dropped_valid", int'(out_valid), 0);
    out_ready = 1'b1;
    tick(3);
    chk("t5_dropped_count", got_d.size(), gi);

    send(5); send(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mid_valid", int'(out_valid), 0);
    chk("t6_mid_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    send(3); send(3); send(3); send(-2);
    chk("t6_out_pending", int'(out_valid), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_data", int'(out_data), 0);
    chk("t6_rst_sat", int'(out_sat), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2); send(2); send(2); send(2);
    tick(2);
    expect_res("t6", 7, 1);
    chk("final_count", got_d.size(), gi);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
